// File: rtl/uart_tx_arb_if.sv
// Requester and TX FIFO signals of the UART TX arbiter.
// master: requesters plus the downstream FIFO; slave: the arbiter.
interface uart_tx_arb_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic       req0_last;
  logic       req1_last;
  logic       req0_ready;
  logic       req1_ready;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_wdata;

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last, tx_full,
    input  req0_ready, req1_ready, tx_push, tx_wdata
  );

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, req0_last, req1_last, tx_full,
    output req0_ready, req1_ready, tx_push, tx_wdata
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Two-requester, packet-locked arbiter feeding a UART TX FIFO.
// Optional idle-lock timeout is built when UART_TX_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner, arbitrating (round-robin on ties)
// GNT0  | req0 (RX echo) owns the TX path until its last byte
// GNT1  | req1 (message source) owns the TX path until its last byte
module uart_tx_arb #(
  parameter int unsigned TO_CYCLES = 16'd50000,
  parameter int unsigned TO_W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         to_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   gnt_valid;
  logic   gnt_last;
  logic   push;
  logic   timeout_hit;

  if (TO_W < 1 || TO_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arb: TO_W and TO_CYCLES must be nonzero");
  end

  // last_gnt resets to req1 so that req0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          state_d = last_gnt_q ? GNT0 : GNT1;
        end else if (bus.req0_valid) begin
          state_d = GNT0;
        end else if (bus.req1_valid) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if ((push && gnt_last) || timeout_hit) begin
          state_d    = IDLE;
          last_gnt_d = (state_q == GNT1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant          = 2'b00;
    busy           = 1'b0;
    gnt_valid      = 1'b0;
    gnt_last       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.tx_wdata   = 8'h00;
    case (state_q)
      GNT0: begin
        grant          = 2'b01;
        busy           = 1'b1;
        gnt_valid      = bus.req0_valid;
        gnt_last       = bus.req0_last;
        bus.req0_ready = ~bus.tx_full;
        bus.tx_wdata   = bus.req0_data;
      end
      GNT1: begin
        grant          = 2'b10;
        busy           = 1'b1;
        gnt_valid      = bus.req1_valid;
        gnt_last       = bus.req1_last;
        bus.req1_ready = ~bus.tx_full;
        bus.tx_wdata   = bus.req1_data;
      end
      default: ;
    endcase
    push        = (bus.req0_ready & bus.req0_valid) | (bus.req1_ready & bus.req1_valid);
    bus.tx_push = push;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            to_err_q;

  // Only a silent owner ages; backpressure from the FIFO is not the owner's fault.
  assign timeout_hit = busy & ~gnt_valid & ~bus.tx_full & (cnt_q == TO_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!busy || gnt_valid || bus.tx_full || timeout_hit) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      to_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      to_err_q <= timeout_hit;
    end
  end

  assign to_err = to_err_q;
`else
  assign timeout_hit = 1'b0;
  assign to_err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed messages, monitor checks every push.
// The timeout scenario is included when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arb;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] grant;
  logic       busy;
  logic       to_err;

  uart_tx_arb_if bus();

  uart_tx_arb #(.TO_CYCLES(TO), .TO_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .grant  (grant),
    .busy   (busy),
    .to_err (to_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] gnt;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   push_cyc[$];
  int   n_push = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic [1:0] g, input logic [7:0] d);
    exp_t e;
    e.gnt  = g;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic int pc(input int i);
    return (i < push_cyc.size()) ? push_cyc[i] : -1;
  endfunction

  // Monitor: every push must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.tx_push === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got data %0h grant %b, required no push", bus.tx_wdata, grant);
      end else begin
        e = exp_q.pop_front();
        check("push_data", {24'h0, bus.tx_wdata}, {24'h0, e.data});
        check("push_grant", {30'h0, grant}, {30'h0, e.gnt});
      end
      check("push_other_ready", {31'h0, (grant == 2'b01) ? bus.req1_ready : bus.req0_ready}, 32'h0);
      push_cyc.push_back(cyc);
      n_push++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int k, input logic v, input logic [7:0] d, input logic l);
    if (k == 0) begin
      bus.req0_valid = v;
      bus.req0_data  = d;
      bus.req0_last  = l;
    end else begin
      bus.req1_valid = v;
      bus.req1_data  = d;
      bus.req1_last  = l;
    end
  endtask

  task automatic send_msg(input int k, input logic [31:0] bytes, input int n, input bit with_last);
    logic hs;
    int   b;
    for (int i = 0; i < n; i++) begin
      drv(k, 1'b1, bytes[8*i +: 8], with_last && (i == n - 1));
      hs = 1'b0;
      b  = 0;
      while (!hs && b < 200) begin
        @(negedge clk);
        hs = (k == 0) ? (bus.req0_ready & bus.req0_valid) : (bus.req1_ready & bus.req1_valid);
        @(posedge clk);
        #1;
        b++;
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: requester %0d byte %0d not accepted, required accept within 200 cycles", k, i);
      end
    end
    drv(k, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_pushes(input int target);
    int b;
    b = 0;
    while (n_push < target && b < 200) begin
      tick();
      b++;
    end
    check("wait_push_bound", {31'h0, n_push >= target}, 32'h1);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_grant"}, {30'h0, grant}, 32'h0);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
    check({name, "_push"}, {31'h0, bus.tx_push}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c0;
    int cfree;
    int p;
    int b;

    // Reset with both requesters already asserting
    rst         = 1'b0;
    bus.tx_full = 1'b0;
    drv(0, 1'b1, 8'hA0, 1'b1);
    drv(1, 1'b1, 8'hB0, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    check("rst_grant", {30'h0, grant}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_push", {31'h0, bus.tx_push}, 32'h0);
    check("rst_wdata", {24'h0, bus.tx_wdata}, 32'h0);
    check("rst_ready0", {31'h0, bus.req0_ready}, 32'h0);
    check("rst_ready1", {31'h0, bus.req1_ready}, 32'h0);
    check("rst_to_err", {31'h0, to_err}, 32'h0);

    // Round-robin of single-byte messages, one idle cycle between pushes
    expect_push(2'b01, 8'hA0);
    expect_push(2'b10, 8'hB0);
    expect_push(2'b01, 8'hA0);
    expect_push(2'b10, 8'hB0);
    tick();
    rst  = 1'b1;
    c0   = cyc;
    base = n_push;
    wait_pushes(base + 4);
    drv(0, 1'b0, 8'h00, 1'b0);
    drv(1, 1'b0, 8'h00, 1'b0);
    check("rr_first_cycle", pc(base), c0 + 1);
    check("rr_gap1", pc(base + 1) - pc(base), 2);
    check("rr_gap2", pc(base + 2) - pc(base + 1), 2);
    check("rr_gap3", pc(base + 3) - pc(base + 2), 2);
    check_idle("rr_end");

    // Three-byte message from req0 alone
    tick();
    expect_push(2'b01, 8'h41);
    expect_push(2'b01, 8'h42);
    expect_push(2'b01, 8'h43);
    base = n_push;
    c0   = cyc;
    send_msg(0, 32'h0043_4241, 3, 1'b1);
    check("m3_first_cycle", pc(base), c0 + 1);
    check("m3_gap1", pc(base + 1) - pc(base), 1);
    check("m3_gap2", pc(base + 2) - pc(base + 1), 1);
    check_idle("m3_end");

    // req1 message locks out a continuously valid req0
    tick();
    expect_push(2'b10, 8'h10);
    expect_push(2'b10, 8'h11);
    expect_push(2'b10, 8'h12);
    expect_push(2'b10, 8'h13);
    expect_push(2'b01, 8'h55);
    base = n_push;
    c0   = cyc;
    fork
      send_msg(1, 32'h1312_1110, 4, 1'b1);
      send_msg(0, 32'h0000_0055, 1, 1'b1);
    join
    check("lock_first_cycle", pc(base), c0 + 1);
    check("lock_gap1", pc(base + 1) - pc(base), 1);
    check("lock_gap2", pc(base + 2) - pc(base + 1), 1);
    check("lock_gap3", pc(base + 3) - pc(base + 2), 1);
    check("lock_handover", pc(base + 4) - pc(base + 3), 2);
    check_idle("lock_end");

    // Reset in the middle of a req0 message
    tick();
    expect_push(2'b01, 8'h61);
    expect_push(2'b01, 8'h62);
    drv(0, 1'b1, 8'h61, 1'b0);
    tick();
    tick();
    drv(0, 1'b1, 8'h62, 1'b0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_push", {31'h0, bus.tx_push}, 32'h0);
    check("midrst_grant", {30'h0, grant}, 32'h0);
    check("midrst_ready0", {31'h0, bus.req0_ready}, 32'h0);
    drv(1, 1'b1, 8'hB1, 1'b1);
    tick();
    @(negedge clk);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_wdata", {24'h0, bus.tx_wdata}, 32'h0);
    expect_push(2'b01, 8'h70);
    expect_push(2'b10, 8'hB1);
    tick();
    rst = 1'b1;
    fork
      send_msg(0, 32'h0000_0070, 1, 1'b1);
      send_msg(1, 32'h0000_00B1, 1, 1'b1);
    join
    check_idle("midrst_end");

    // FIFO full for 5 cycles in the middle of a req1 message
    tick();
    expect_push(2'b10, 8'h10);
    expect_push(2'b10, 8'h11);
    expect_push(2'b10, 8'h12);
    expect_push(2'b10, 8'h13);
    base  = n_push;
    cfree = -100;
    fork
      send_msg(1, 32'h1312_1110, 4, 1'b1);
      begin
        wait_pushes(base + 2);
        bus.tx_full = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("full_push", {31'h0, bus.tx_push}, 32'h0);
          check("full_ready1", {31'h0, bus.req1_ready}, 32'h0);
          check("full_grant", {30'h0, grant}, 32'h2);
          tick();
        end
        bus.tx_full = 1'b0;
        cfree = cyc;
      end
    join
    check("full_resume_cycle", pc(base + 2), cfree);
    check("full_gap", pc(base + 3) - pc(base + 2), 1);
    check_idle("full_end");

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Owner stalls without a last byte; the lock times out and req1 is served
    tick();
    expect_push(2'b01, 8'h80);
    expect_push(2'b10, 8'h90);
    base = n_push;
    send_msg(0, 32'h0000_0080, 1, 1'b0);
    p = pc(base);
    fork
      send_msg(1, 32'h0000_0090, 1, 1'b1);
      begin
        b = 0;
        while (cyc < p + 8 && b < 50) begin
          tick();
          b++;
        end
        @(negedge clk);
        check("to_before_err", {31'h0, to_err}, 32'h0);
        check("to_before_grant", {30'h0, grant}, 32'h1);
        @(negedge clk);
        check("to_pulse", {31'h0, to_err}, 32'h1);
        check("to_pulse_grant", {30'h0, grant}, 32'h0);
        @(negedge clk);
        check("to_pulse_end", {31'h0, to_err}, 32'h0);
        check("to_next_grant", {30'h0, grant}, 32'h2);
      end
    join
    check("to_service_cycle", pc(base + 1), p + 10);
`endif

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
